// File: rtl/ps2_key_matrix_if.sv
// rtl/ps2_key_matrix_if.sv - PS/2 keyboard lines, CPU matrix read port and key status outputs
interface ps2_key_matrix_if;
  logic        ps2_kbd_clk;
  logic        ps2_kbd_data;
  logic [15:0] addr;
  logic [7:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;

  modport master (
    output ps2_kbd_clk, ps2_kbd_data, addr,
    input  key_data, Fn, mod
  );

  modport slave (
    input  ps2_kbd_clk, ps2_kbd_data, addr,
    output key_data, Fn, mod
  );
endinterface

// File: rtl/ps2_key_matrix.sv
// rtl/ps2_key_matrix.sv - PS/2 set-2 scancode receiver driving a 9x8 active-low CPU key matrix
// Build macro CURSOR_KEYS_EN: maps E0 75/72/6B/74 onto row8 bits 1..4 (Up/Down/Left/Right).
module ps2_key_matrix #(
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic            clk_sys,
  input  logic            reset,
  ps2_key_matrix_if.slave bus
);
  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam int SP_LSHIFT = 0;
  localparam int SP_RSHIFT = 1;
  localparam int SP_LCTRL  = 2;
  localparam int SP_RCTRL  = 3;
  localparam int SP_LALT   = 4;
  localparam int SP_RALT   = 5;
  localparam int SP_F10    = 6;
  localparam int SP_F11    = 7;

  typedef enum logic [0:0] {ST_IDLE, ST_RECV} rx_state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          kbd_fall, kbd_bit;

  rx_state_t     state, state_nx;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          timeout, frame_end, frame_ok;
  logic [7:0]    rx_byte;

  logic          ext_flag, rel_flag;
  logic [7:0]    map_key;
  logic          map_hit;
  logic [3:0]    map_row;
  logic [2:0]    map_bit;
  logic [7:0]    map_special;

  logic [7:0]    mtx [0:8];
  logic [7:0]    spec_held;
  logic [7:0]    row_val [0:8];
  logic          unused_addr_lo;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], bus.ps2_kbd_clk};
      dat_sync <= {dat_sync[0], bus.ps2_kbd_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign kbd_fall = clk_prev & ~clk_sync[1];
  assign kbd_bit  = dat_sync[1];

  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (kbd_fall && !kbd_bit) state_nx = ST_RECV;
      ST_RECV: if (timeout || frame_end) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bit 10 is the stop bit; start was already checked when leaving idle.
  always_comb begin
    timeout   = (state == ST_RECV) && !kbd_fall && (to_cnt == TO_LAST);
    frame_end = (state == ST_RECV) && kbd_fall && (bit_cnt == 4'd10);
    frame_ok  = frame_end && kbd_bit && (^shreg);
    rx_byte   = shreg[7:0];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt <= 4'd0;
      shreg   <= 9'd0;
      to_cnt  <= '0;
    end else if (state == ST_IDLE) begin
      bit_cnt <= (kbd_fall && !kbd_bit) ? 4'd1 : 4'd0;
      shreg   <= 9'd0;
      to_cnt  <= '0;
    end else if (timeout || frame_end) begin
      bit_cnt <= 4'd0;
      to_cnt  <= '0;
    end else if (kbd_fall) begin
      shreg   <= {kbd_bit, shreg[8:1]};
      bit_cnt <= bit_cnt + 4'd1;
      to_cnt  <= '0;
    end else begin
      to_cnt  <= to_cnt + 1'b1;
    end
  end

  function automatic logic [7:0] key_at(input logic [3:0] r, input logic [2:0] b);
    return {1'b1, r, b};
  endfunction

  always_comb begin
    map_key     = 8'd0;
    map_special = 8'd0;
    if (!ext_flag) begin
      case (rx_byte)
        8'h12: map_special[SP_LSHIFT] = 1'b1;
        8'h59: map_special[SP_RSHIFT] = 1'b1;
        8'h14: map_special[SP_LCTRL]  = 1'b1;
        8'h11: map_special[SP_LALT]   = 1'b1;
        8'h09: map_special[SP_F10]    = 1'b1;
        8'h78: map_special[SP_F11]    = 1'b1;
        8'h1A: map_key = key_at(4'd0, 3'd1);
        8'h22: map_key = key_at(4'd0, 3'd2);
        8'h21: map_key = key_at(4'd0, 3'd3);
        8'h2A: map_key = key_at(4'd0, 3'd4);
        8'h05: map_key = key_at(4'd0, 3'd5);
        8'h06: map_key = key_at(4'd0, 3'd6);
        8'h04: map_key = key_at(4'd0, 3'd7);
        8'h1C: map_key = key_at(4'd1, 3'd0);
        8'h1B: map_key = key_at(4'd1, 3'd1);
        8'h23: map_key = key_at(4'd1, 3'd2);
        8'h2B: map_key = key_at(4'd1, 3'd3);
        8'h34: map_key = key_at(4'd1, 3'd4);
        8'h0C: map_key = key_at(4'd1, 3'd5);
        8'h03: map_key = key_at(4'd1, 3'd6);
        8'h0B: map_key = key_at(4'd1, 3'd7);
        8'h15: map_key = key_at(4'd2, 3'd0);
        8'h1D: map_key = key_at(4'd2, 3'd1);
        8'h24: map_key = key_at(4'd2, 3'd2);
        8'h2D: map_key = key_at(4'd2, 3'd3);
        8'h2C: map_key = key_at(4'd2, 3'd4);
        8'h83: map_key = key_at(4'd2, 3'd5);
        8'h0A: map_key = key_at(4'd2, 3'd6);
        8'h01: map_key = key_at(4'd2, 3'd7);
        8'h16: map_key = key_at(4'd3, 3'd0);
        8'h1E: map_key = key_at(4'd3, 3'd1);
        8'h26: map_key = key_at(4'd3, 3'd2);
        8'h25: map_key = key_at(4'd3, 3'd3);
        8'h2E: map_key = key_at(4'd3, 3'd4);
        8'h76: map_key = key_at(4'd3, 3'd5);
        8'h0D: map_key = key_at(4'd3, 3'd6);
        8'h58: map_key = key_at(4'd3, 3'd7);
        8'h45: map_key = key_at(4'd4, 3'd0);
        8'h46: map_key = key_at(4'd4, 3'd1);
        8'h3E: map_key = key_at(4'd4, 3'd2);
        8'h3D: map_key = key_at(4'd4, 3'd3);
        8'h36: map_key = key_at(4'd4, 3'd4);
        8'h66: map_key = key_at(4'd4, 3'd5);
        8'h4D: map_key = key_at(4'd5, 3'd0);
        8'h44: map_key = key_at(4'd5, 3'd1);
        8'h43: map_key = key_at(4'd5, 3'd2);
        8'h3C: map_key = key_at(4'd5, 3'd3);
        8'h35: map_key = key_at(4'd5, 3'd4);
        8'h5A: map_key = key_at(4'd6, 3'd0);
        8'h4B: map_key = key_at(4'd6, 3'd1);
        8'h42: map_key = key_at(4'd6, 3'd2);
        8'h3B: map_key = key_at(4'd6, 3'd3);
        8'h33: map_key = key_at(4'd6, 3'd4);
        8'h29: map_key = key_at(4'd7, 3'd0);
        8'h3A: map_key = key_at(4'd7, 3'd2);
        8'h31: map_key = key_at(4'd7, 3'd3);
        8'h32: map_key = key_at(4'd7, 3'd4);
        default: ;
      endcase
    end else begin
      case (rx_byte)
        8'h14: map_special[SP_RCTRL] = 1'b1;
        8'h11: map_special[SP_RALT]  = 1'b1;
`ifdef CURSOR_KEYS_EN
        8'h75: map_key = key_at(4'd8, 3'd1);
        8'h72: map_key = key_at(4'd8, 3'd2);
        8'h6B: map_key = key_at(4'd8, 3'd3);
        8'h74: map_key = key_at(4'd8, 3'd4);
`endif
        default: ;
      endcase
    end
  end

  assign map_hit = map_key[7];
  assign map_row = map_key[6:3];
  assign map_bit = map_key[2:0];

  // Writing the held level rather than toggling keeps repeated makes/breaks idempotent.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_flag  <= 1'b0;
      rel_flag  <= 1'b0;
      spec_held <= 8'd0;
      for (int r = 0; r < 9; r++) mtx[r] <= 8'd0;
    end else if (frame_ok) begin
      if (rx_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        rel_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
        for (int r = 0; r < 9; r++)
          if (map_hit && map_row == 4'(r)) mtx[r][map_bit] <= ~rel_flag;
        for (int s = 0; s < 8; s++)
          if (map_special[s]) spec_held[s] <= ~rel_flag;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 9; r++) row_val[r] = mtx[r];
    row_val[0][0] = mtx[0][0] | spec_held[SP_LSHIFT] | spec_held[SP_RSHIFT];
    row_val[7][1] = mtx[7][1] | spec_held[SP_LALT]   | spec_held[SP_RALT];
    row_val[8][0] = mtx[8][0] | spec_held[SP_LCTRL]  | spec_held[SP_RCTRL];
  end

  // Row 8 has no address line of its own; it answers only when no other row is selected.
  always_comb begin
    bus.key_data = 8'hFF;
    for (int r = 0; r < 8; r++)
      if (!bus.addr[8 + r]) bus.key_data = bus.key_data & ~row_val[r];
    if (bus.addr[15:8] == 8'hFF) bus.key_data = bus.key_data & ~row_val[8];
  end

  assign bus.Fn  = {spec_held[SP_F11], spec_held[SP_F10],
                    mtx[2][7:5], mtx[1][7:5], mtx[0][7:5]};
  assign bus.mod = {row_val[7][1], row_val[8][0], row_val[0][0]};

  assign unused_addr_lo = ^bus.addr[7:0];
endmodule

// File: tb/tb_ps2_key_matrix.sv
// tb/tb_ps2_key_matrix.sv - directed table-driven bench for ps2_key_matrix
module tb_ps2_key_matrix;
  localparam int TO_CYC = 4096;

  typedef struct {
    int          n;
    logic [7:0]  b0, b1, b2;
    logic [15:0] addr;
    logic [7:0]  kd;
    logic [10:0] fn;
    logic [2:0]  md;
  } vec_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  vec_t vq[$];

  ps2_key_matrix_if ifc();

  ps2_key_matrix #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (ifc.slave)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ifc.ps2_kbd_data = b;
    cyc(10);
    ifc.ps2_kbd_clk = 1'b0;
    cyc(20);
    ifc.ps2_kbd_clk = 1'b1;
    cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(stop_bit);
    ifc.ps2_kbd_data = 1'b1;
    cyc(4);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic add(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input logic [15:0] a, input logic [7:0] kd, input logic [10:0] fn,
                     input logic [2:0] md);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.addr = a; v.kd = kd; v.fn = fn; v.md = md;
    vq.push_back(v);
  endtask

  task automatic probe(input string tag, input logic [15:0] a, input logic [7:0] kd);
    ifc.addr = a;
    cyc(1);
    chk(tag, ifc.key_data, kd);
  endtask

  initial begin
    ifc.ps2_kbd_clk  = 1'b1;
    ifc.ps2_kbd_data = 1'b1;
    ifc.addr         = 16'h00FE;

    // Fn expectations are Fn[11:1] packed with Fn[1] at bit 0.
    add(1, 8'h1C, 0, 0, 16'hFDFE, 8'hFE, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h1C, 0, 16'hFDFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h12, 0, 0, 16'hFEFE, 8'hFE, 11'h000, 3'd1);
    add(1, 8'h1A, 0, 0, 16'hFEFE, 8'hFC, 11'h000, 3'd1);
    add(0, 0, 0, 0, 16'hFFFE, 8'hFF, 11'h000, 3'd1);
    add(1, 8'h59, 0, 0, 16'hFEFE, 8'hFC, 11'h000, 3'd1);
    add(2, 8'hF0, 8'h12, 0, 16'hFEFE, 8'hFC, 11'h000, 3'd1);
    add(2, 8'hF0, 8'h59, 0, 16'hFEFE, 8'hFD, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h1A, 0, 16'hFEFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h14, 0, 0, 16'hFFFE, 8'hFE, 11'h000, 3'd2);
    add(1, 8'h78, 0, 0, 16'hFFFE, 8'hFE, 11'h400, 3'd2);
    add(2, 8'hF0, 8'h14, 0, 16'hFFFE, 8'hFF, 11'h400, 3'd0);
    add(2, 8'hF0, 8'h78, 0, 16'hFFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h05, 0, 0, 16'hFEFE, 8'hDF, 11'h001, 3'd0);
    add(1, 8'h05, 0, 0, 16'hFEFE, 8'hDF, 11'h001, 3'd0);
    add(2, 8'hF0, 8'h05, 0, 16'hFEFE, 8'hFF, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h05, 0, 16'hFEFE, 8'hFF, 11'h000, 3'd0);
    add(2, 8'hE0, 8'h11, 0, 16'h7FFE, 8'hFD, 11'h000, 3'd4);
    add(1, 8'h11, 0, 0, 16'h7FFE, 8'hFD, 11'h000, 3'd4);
    add(3, 8'hE0, 8'hF0, 8'h11, 16'h7FFE, 8'hFD, 11'h000, 3'd4);
    add(2, 8'hF0, 8'h11, 0, 16'h7FFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h16, 0, 0, 16'hF7FE, 8'hFE, 11'h000, 3'd0);
    add(1, 8'h45, 0, 0, 16'hE7FE, 8'hFE, 11'h000, 3'd0);
    add(1, 8'h46, 0, 0, 16'hE7FE, 8'hFC, 11'h000, 3'd0);
    add(0, 0, 0, 0, 16'h00FE, 8'hFC, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h16, 0, 16'hF7FE, 8'hFF, 11'h000, 3'd0);
    add(0, 0, 0, 0, 16'hEFFE, 8'hFC, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h45, 0, 16'hEFFE, 8'hFD, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h46, 0, 16'hEFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h0A, 0, 0, 16'hFBFE, 8'hBF, 11'h080, 3'd0);
    add(2, 8'hF0, 8'h0A, 0, 16'hFBFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h1F, 0, 0, 16'h00FE, 8'hFF, 11'h000, 3'd0);
    add(2, 8'hE0, 8'h14, 0, 16'hFFFE, 8'hFE, 11'h000, 3'd2);
    add(3, 8'hE0, 8'hF0, 8'h14, 16'hFFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h76, 0, 0, 16'hF7FE, 8'hDF, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h76, 0, 16'hF7FE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h66, 0, 0, 16'hEFFE, 8'hDF, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h66, 0, 16'hEFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h09, 0, 0, 16'hFFFE, 8'hFF, 11'h200, 3'd0);
    add(2, 8'hF0, 8'h09, 0, 16'hFFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h75, 0, 0, 16'hFFFE, 8'hFF, 11'h000, 3'd0);

    cyc(5);
    reset = 1'b0;
    cyc(1);
    probe("reset kd rows", 16'h00FE, 8'hFF);
    probe("reset kd row8", 16'hFFFE, 8'hFF);
    chk("reset Fn", ifc.Fn, 11'h000);
    chk("reset mod", ifc.mod, 3'd0);

    foreach (vq[i]) begin
      if (vq[i].n > 0) send(vq[i].b0);
      if (vq[i].n > 1) send(vq[i].b1);
      if (vq[i].n > 2) send(vq[i].b2);
      ifc.addr = vq[i].addr;
      cyc(2);
      chk($sformatf("vec%0d key_data", i), ifc.key_data, vq[i].kd);
      chk($sformatf("vec%0d Fn", i), ifc.Fn, vq[i].fn);
      chk($sformatf("vec%0d mod", i), ifc.mod, vq[i].md);
    end

    // Bad parity make is dropped; bad parity F0 must not arm the release flag.
    send_frame(8'h1C, 1'b1, 1'b1);
    probe("badpar make", 16'hFDFE, 8'hFF);
    send_frame(8'hF0, 1'b1, 1'b1);
    send(8'h1C);
    probe("badpar F0 then make", 16'hFDFE, 8'hFE);
    send(8'hF0); send(8'h1C);
    probe("valid break after badpar", 16'hFDFE, 8'hFF);
    send_frame(8'h1C, 1'b0, 1'b0);
    probe("bad stop", 16'hFDFE, 8'hFF);

    // Partial frame abandoned by the idle timeout.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 2 || i == 3);
    ifc.ps2_kbd_data = 1'b1;
    cyc(TO_CYC + 400);
    send(8'h1C);
    probe("timeout then make", 16'hFDFE, 8'hFE);
    send(8'hF0); send(8'h1C);
    probe("timeout break", 16'hFDFE, 8'hFF);

    send(8'hE0); send(8'h75);
`ifdef CURSOR_KEYS_EN
    probe("cursor up", 16'hFFFE, 8'hFD);
`else
    probe("cursor up", 16'hFFFE, 8'hFF);
`endif
    send(8'hE0); send(8'hF0); send(8'h75);
    probe("cursor up release", 16'hFFFE, 8'hFF);

    // Reset mid-frame with keys held and a release prefix pending.
    send(8'h1C); send(8'h12); send(8'h14); send(8'h78);
    probe("pre-reset row1", 16'hFDFE, 8'hFE);
    chk("pre-reset mod", ifc.mod, 3'd3);
    send(8'hF0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 2 || i == 3);
    ifc.ps2_kbd_data = 1'b1;
    reset = 1'b1;
    ifc.addr = 16'h00FE;
    cyc(1);
    chk("midreset kd rows", ifc.key_data, 8'hFF);
    chk("midreset Fn", ifc.Fn, 11'h000);
    chk("midreset mod", ifc.mod, 3'd0);
    reset = 1'b0;
    probe("midreset kd row8", 16'hFFFE, 8'hFF);
    cyc(5);
    send(8'h1C);
    probe("post-reset make", 16'hFDFE, 8'hFE);
    send(8'hF0); send(8'h1C);
    probe("post-reset break", 16'hFDFE, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
